// File: rtl/escalonador_rr.sv
// escalonador_rr
// Round-robin preemptive process scheduler feeding the OS-control block.
// A quantum counter preempts the running process, and a halt pulse lets it
// give up the CPU early. Every switch goes through a request/acknowledge
// handshake with the pipeline so that context is saved before a new process
// ID is issued. All outputs are registered.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   enable       OS mode active (high once the BIOS has finished)
//   proc_valid   bit i = process slot i is live/runnable
//   halt_proc    one-cycle pulse: running process finished or yielded
//   troca_ack    pipeline has drained and saved context
//   troca_req    request pipeline drain/context save
//   set_ctx      one-cycle strobe: id_proc_novo is valid
//   id_proc_novo ID of the process to run next
//   quantum_cnt  current quantum count (debug)
//   ocioso       scheduler idle: no runnable process or disabled
module escalonador_rr #(
  parameter int QUANTUM = 256,
  parameter int NPROC   = 4,
  parameter int PID_W   = 2,
  localparam int CNT_W  = $clog2(QUANTUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NPROC-1:0] proc_valid,
  input  logic             halt_proc,
  input  logic             troca_ack,
  output logic             troca_req,
  output logic             set_ctx,
  output logic [PID_W-1:0] id_proc_novo,
  output logic [CNT_W-1:0] quantum_cnt,
  output logic             ocioso
);

  typedef enum logic [1:0] {IDLE, RUN, REQ, SET} state_t;

  state_t           state, state_d;
  logic [PID_W-1:0] atual, atual_d;
  logic [PID_W-1:0] sel_q, sel_d;
  logic [PID_W-1:0] id_d;
  logic [CNT_W-1:0] cnt_d;
  logic             troca_req_d, set_ctx_d, ocioso_d;

  logic [PID_W-1:0] low_pid, rr_pid;
  logic             rr_found;
  logic             expirou;
  int               idx;

  // Candidate selection. The low-index search is used when leaving IDLE; the
  // round-robin search starts just after the current process and visits the
  // current one last, so a sole survivor is re-selected. Loops run from the
  // far end so the closest candidate is the last one written.
  always_comb begin
    low_pid  = '0;
    rr_pid   = '0;
    rr_found = 1'b0;
    idx      = 0;
    for (int i = NPROC - 1; i >= 0; i--) begin
      if (proc_valid[i]) begin
        low_pid = PID_W'(i);
      end
    end
    for (int k = NPROC; k >= 1; k--) begin
      idx = (int'(atual) + k) % NPROC;
      if (proc_valid[idx]) begin
        rr_pid   = PID_W'(idx);
        rr_found = 1'b1;
      end
    end
  end

  assign expirou = (quantum_cnt == CNT_W'(QUANTUM - 1));

  // State register plus the registered outputs; reset abandons any
  // handshake that is in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      atual        <= '0;
      sel_q        <= '0;
      troca_req    <= 1'b0;
      set_ctx      <= 1'b0;
      id_proc_novo <= '0;
      quantum_cnt  <= '0;
      ocioso       <= 1'b1;
    end else begin
      state        <= state_d;
      atual        <= atual_d;
      sel_q        <= sel_d;
      troca_req    <= troca_req_d;
      set_ctx      <= set_ctx_d;
      id_proc_novo <= id_d;
      quantum_cnt  <= cnt_d;
      ocioso       <= ocioso_d;
    end
  end

  // Next-state logic. proc_valid is only looked at when a process is being
  // chosen, and the choice is captured in sel_q for the SET cycle.
  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    case (state)
      IDLE: begin
        if (enable && (proc_valid != '0)) begin
          state_d = SET;
          sel_d   = low_pid;
        end
      end
      SET: begin
        state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (halt_proc || expirou) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (troca_ack) begin
          if (enable && rr_found) begin
            state_d = SET;
            sel_d   = rr_pid;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values. The quantum does not advance during the strobe
  // cycle itself: that is the cycle the OS-control block latches the new
  // ID, so the process gets QUANTUM full cycles after it. The count is held
  // while a switch is pending and cleared whenever the scheduler goes idle.
  always_comb begin
    troca_req_d = (state_d == REQ);
    set_ctx_d   = 1'b0;
    id_d        = id_proc_novo;
    atual_d     = atual;
    cnt_d       = quantum_cnt;
    ocioso_d    = ocioso;
    case (state)
      SET: begin
        set_ctx_d = 1'b1;
        id_d      = sel_q;
        atual_d   = sel_q;
        cnt_d     = '0;
        ocioso_d  = 1'b0;
      end
      RUN: begin
        if (state_d == RUN && !set_ctx) begin
          cnt_d = quantum_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == IDLE) begin
      cnt_d    = '0;
      ocioso_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_escalonador_rr.sv
// tb_escalonador_rr
// Self-checking bench for escalonador_rr with QUANTUM=8, NPROC=4. A
// behavioural model tracks what the scheduler is doing (idle, running,
// waiting for ack, about to strobe) and predicts every output each cycle;
// directed sequences add hand-computed expectations at key points.
module tb_escalonador_rr;

  localparam int Q  = 8;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NP-1:0] proc_valid;
  logic          halt_proc;
  logic          troca_ack;
  logic          troca_req;
  logic          set_ctx;
  logic [1:0]    id_proc_novo;
  logic [2:0]    quantum_cnt;
  logic          ocioso;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  escalonador_rr #(.QUANTUM(Q), .NPROC(NP), .PID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .proc_valid   (proc_valid),
    .halt_proc    (halt_proc),
    .troca_ack    (troca_ack),
    .troca_req    (troca_req),
    .set_ctx      (set_ctx),
    .id_proc_novo (id_proc_novo),
    .quantum_cnt  (quantum_cnt),
    .ocioso       (ocioso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generic comparison used by both the per-cycle checker and directed checks.
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [NP-1:0] v,
                               input logic h, input logic a);
    enable     = en;
    proc_valid = v;
    halt_proc  = h;
    troca_ack  = a;
  endtask

  // First valid slot scanning from 'start' upward with wrap-around.
  function automatic int pick(input int start, input logic [NP-1:0] v);
    for (int off = 0; off < NP; off++) begin
      if (v[(start + off) % NP]) return (start + off) % NP;
    end
    return -1;
  endfunction

  // Behavioural model.
  int  m_req, m_set, m_id, m_cnt, m_idle;
  int  cur, pend, running, waiting, p, o_set;
  bit  model_ready = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_req = 0; m_set = 0; m_id = 0; m_cnt = 0; m_idle = 1;
      cur = 0; pend = -1; running = 0; waiting = 0;
      model_ready = 1;
    end else if (pend >= 0) begin
      m_set = 1; m_id = pend; cur = pend; m_cnt = 0; m_idle = 0; m_req = 0;
      running = 1; pend = -1;
    end else begin
      o_set = m_set;
      m_set = 0;
      if (waiting != 0) begin
        if (troca_ack) begin
          waiting = 0;
          m_req = 0;
          p = pick(cur + 1, proc_valid);
          if (enable && p >= 0) pend = p;
          else begin m_idle = 1; m_cnt = 0; end
        end
      end else if (running != 0) begin
        if (!enable) begin
          running = 0; m_idle = 1; m_cnt = 0;
        end else if (halt_proc || m_cnt == Q - 1) begin
          running = 0; waiting = 1; m_req = 1;
        end else if (o_set == 0) begin
          m_cnt++;
        end
      end else begin
        if (enable && proc_valid != 0) pend = pick(0, proc_valid);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("model troca_req", troca_req, m_req);
      checkOutput("model set_ctx", set_ctx, m_set);
      checkOutput("model id_proc_novo", id_proc_novo, m_id);
      checkOutput("model quantum_cnt", quantum_cnt, m_cnt);
      checkOutput("model ocioso", ocioso, m_idle);
    end
  end

  // Bounded waits on DUT events; an expired bound counts as a failure.
  task automatic waitSet(input string name, input int exp_id);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (set_ctx) seen = 1;
    end
    checkOutput({name, " set_ctx seen"}, int'(seen), 1);
    if (seen) checkOutput({name, " id"}, id_proc_novo, exp_id);
  endtask

  task automatic waitReq(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (troca_req) seen = 1;
    end
    checkOutput({name, " troca_req seen"}, int'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int last_set;
    reset = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset troca_req", troca_req, 0);
    checkOutput("reset set_ctx", set_ctx, 0);
    checkOutput("reset id", id_proc_novo, 0);
    checkOutput("reset cnt", quantum_cnt, 0);
    checkOutput("reset ocioso", ocioso, 1);

    // First dispatch: lowest valid slot of 0110 is 1, strobe two cycles later.
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("start set_ctx early", set_ctx, 0);
    @(negedge clk);
    checkOutput("start set_ctx", set_ctx, 1);
    checkOutput("start id", id_proc_novo, 1);
    checkOutput("start ocioso", ocioso, 0);
    @(negedge clk);
    checkOutput("start set_ctx drop", set_ctx, 0);
    checkOutput("start cnt", quantum_cnt, 0);

    // Disable while running: straight to idle, no handshake.
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disable ocioso", ocioso, 1);
    checkOutput("disable cnt", quantum_cnt, 0);
    checkOutput("disable troca_req", troca_req, 0);

    // Full rotation with ack tied high: strobe every 11 cycles, IDs 0..3,0.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
    waitSet("rot0", 0);
    last_set = cyc;
    for (int k = 1; k <= 4; k++) begin
      waitReq("rot");
      checkOutput("rot cnt at req", quantum_cnt, Q - 1);
      waitSet("rot", k % NP);
      checkOutput("rot interval", cyc - last_set, 11);
      last_set = cyc;
    end
    waitSet("to pid1", 1);
    waitSet("to pid2", 2);

    // Halt PID 2 at count 3 and drop it from the valid set.
    repeat (4) @(negedge clk);
    checkOutput("halt cnt before", quantum_cnt, 3);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b1);
    @(negedge clk);
    halt_proc = 1'b0;
    checkOutput("halt troca_req", troca_req, 1);
    checkOutput("halt cnt frozen", quantum_cnt, 3);
    waitSet("after halt", 3);

    // Delayed ack: request held for five cycles with the count frozen.
    troca_ack = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("delay cnt before", quantum_cnt, 1);
    halt_proc = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      halt_proc = 1'b0;
      checkOutput("delay troca_req", troca_req, 1);
      checkOutput("delay cnt frozen", quantum_cnt, 1);
      checkOutput("delay set_ctx", set_ctx, 0);
    end
    troca_ack = 1'b1;
    @(negedge clk);
    checkOutput("delay req cleared", troca_req, 0);
    waitSet("after delay", 0);

    // Only slot 2 valid: it is re-selected with a fresh strobe.
    proc_valid = 4'b0100;
    waitSet("solo first", 2);
    waitSet("solo again", 2);
    proc_valid = 4'b0000;
    repeat (12) @(negedge clk);
    checkOutput("empty ocioso", ocioso, 1);
    checkOutput("empty set_ctx", set_ctx, 0);
    checkOutput("empty troca_req", troca_req, 0);
    checkOutput("empty cnt", quantum_cnt, 0);

    // Reset during a pending request.
    proc_valid = 4'b0010;
    waitSet("pre-reset", 1);
    troca_ack = 1'b0;
    @(negedge clk);
    halt_proc = 1'b1;
    @(negedge clk);
    halt_proc = 1'b0;
    checkOutput("pre-reset troca_req", troca_req, 1);
    reset  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    checkOutput("mid-req reset troca_req", troca_req, 0);
    checkOutput("mid-req reset id", id_proc_novo, 0);
    checkOutput("mid-req reset ocioso", ocioso, 1);
    checkOutput("mid-req reset cnt", quantum_cnt, 0);
    reset     = 1'b1;
    troca_ack = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("late ack troca_req", troca_req, 0);
    checkOutput("late ack set_ctx", set_ctx, 0);
    checkOutput("late ack ocioso", ocioso, 1);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
